lfsr_period_monitor: RTL and testbench

Downstream checker that consumes the per-cycle `computed_value` stream of an `lfsr_4bit` (or wider LFSR) instance and measures its sequence period. On a start request it latches the current sample as the reference, counts clock edges until the reference value reappears, and reports the period. It also flags maximal-length sequences, stuck (fixed-point) states and non-returning sequences. It sits beside the LFSR in the test/characterisation path and gives benches and on-chip self-test a pass/fail verdict for a `taps`/`reset_value` pair.

---
 rtl/lfsr_period_monitor_pkg.sv | 15 +
 rtl/lfsr_cycle_counter.sv | 33 +++
 rtl/lfsr_period_monitor.sv | 118 +++++++++++
 tb/tb_lfsr_period_monitor.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/lfsr_period_monitor_pkg.sv
// Shared definitions for the LFSR period monitor: FSM state encoding and
// the maximal-period helper.
package lfsr_period_monitor_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      DONE    = 2'd2
   } mon_state_t;

   function automatic int unsigned max_period(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/lfsr_cycle_counter.sv
// WIDTH+1-bit edge counter with synchronous load-to-1, enable and a
// terminal flag at 2^WIDTH.
module lfsr_cycle_counter
   import lfsr_period_monitor_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_load,
   input  logic           i_en,
   output logic [WIDTH:0] o_count,
   output logic           o_terminal
);

   localparam logic [WIDTH:0] C_TERM = {1'b1, {WIDTH{1'b0}}};

   logic [WIDTH:0] r_count;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= (WIDTH+1)'(1);
      end else if (i_en) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count    = r_count;
   assign o_terminal = (r_count == C_TERM);

endmodule

// File: rtl/lfsr_period_monitor.sv
// Measures the period of an LFSR output stream: latches a reference sample on
// start and counts edges until it reappears, flagging maximal/stuck/timeout.
module lfsr_period_monitor
   import lfsr_period_monitor_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] sample_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   period,
   output logic             maximal,
   output logic             stuck,
   output logic             timeout
);

   localparam logic [WIDTH:0] C_MAX = (WIDTH+1)'(max_period(WIDTH));

   mon_state_t       r_state;
   logic [WIDTH-1:0] r_ref;
   logic [WIDTH-1:0] r_prev;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH:0]   r_period;
   logic             r_maximal;
   logic             r_stuck;
   logic             r_timeout;

   logic [WIDTH:0]   w_count;
   logic             w_terminal;
   logic             w_load;
   logic             w_en;
   logic             w_hit_ref;
   logic             w_hit_prev;

   assign w_hit_ref  = (sample_in == r_ref);
   assign w_hit_prev = (sample_in == r_prev);
   assign w_load     = (r_state != MEASURE) && start;
   // Count only on edges where none of the terminating rules fire.
   assign w_en       = (r_state == MEASURE) && !w_hit_ref && !w_hit_prev && !w_terminal;

   lfsr_cycle_counter #(
      .WIDTH (WIDTH)
   ) u_counter (
      .i_clk      (clock),
      .i_rst_n    (reset),
      .i_load     (w_load),
      .i_en       (w_en),
      .o_count    (w_count),
      .o_terminal (w_terminal)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_ref     <= '0;
         r_prev    <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_period  <= '0;
         r_maximal <= 1'b0;
         r_stuck   <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_ref     <= sample_in;
                  r_prev    <= sample_in;
                  r_period  <= '0;
                  r_maximal <= 1'b0;
                  r_stuck   <= 1'b0;
                  r_timeout <= 1'b0;
                  r_busy    <= 1'b1;
                  r_state   <= MEASURE;
               end
            end
            MEASURE: begin
               if (w_hit_ref) begin
                  r_period  <= w_count;
                  r_maximal <= (w_count == C_MAX);
                  r_stuck   <= (w_count == (WIDTH+1)'(1));
                  r_done    <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= DONE;
               end else if (w_hit_prev) begin
                  r_stuck   <= 1'b1;
                  r_period  <= '0;
                  r_done    <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= DONE;
               end else if (w_terminal) begin
                  r_timeout <= 1'b1;
                  r_period  <= '0;
                  r_done    <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= DONE;
               end else begin
                  r_prev <= sample_in;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign period  = r_period;
   assign maximal = r_maximal;
   assign stuck   = r_stuck;
   assign timeout = r_timeout;

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Randomized and directed bench for lfsr_period_monitor, checked against a
// sequence-scanning reference model.
module tb_lfsr_period_monitor;

   localparam int unsigned W    = 4;
   localparam int unsigned NSEQ = 40;

   logic           clock = 1'b0;
   logic           reset = 1'b0;
   logic           start = 1'b0;
   logic [W-1:0]   sample_in = '0;
   logic           busy;
   logic           done;
   logic [W:0]     period;
   logic           maximal;
   logic           stuck;
   logic           timeout;

   int unsigned    n_total = 0;
   int unsigned    n_bad   = 0;
   int unsigned    seq [0:NSEQ-1];

   lfsr_period_monitor #(
      .WIDTH (W)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .sample_in (sample_in),
      .busy      (busy),
      .done      (done),
      .period    (period),
      .maximal   (maximal),
      .stuck     (stuck),
      .timeout   (timeout)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".busy"},    32'(busy),    0);
      chk({tag, ".done"},    32'(done),    0);
      chk({tag, ".period"},  32'(period),  0);
      chk({tag, ".maximal"}, 32'(maximal), 0);
      chk({tag, ".stuck"},   32'(stuck),   0);
      chk({tag, ".timeout"}, 32'(timeout), 0);
   endtask

   // Scan the sample stream as seen edge by edge after the start edge.
   task automatic model(output int unsigned k_dec, output int unsigned e_per,
                        output int unsigned e_max, output int unsigned e_stk,
                        output int unsigned e_to);
      k_dec = 0; e_per = 0; e_max = 0; e_stk = 0; e_to = 0;
      for (int unsigned k = 1; k <= (1 << W); k++) begin
         if (seq[k] == seq[0]) begin
            e_per = k;
            e_max = (k == (1 << W) - 1) ? 1 : 0;
            e_stk = (k == 1) ? 1 : 0;
            k_dec = k;
            break;
         end
         if (seq[k] == seq[k-1]) begin
            e_stk = 1;
            k_dec = k;
            break;
         end
         if (k == (1 << W)) begin
            e_to  = 1;
            k_dec = k;
         end
      end
   endtask

   task automatic gen_lfsr(input int unsigned taps, input int unsigned seed, input int unsigned skip);
      int unsigned s;
      s = seed;
      for (int unsigned i = 0; i < skip; i++)
         s = (s >> 1) ^ (((s & 1) != 0) ? taps : 0);
      for (int unsigned i = 0; i < NSEQ; i++) begin
         seq[i] = s;
         s = (s >> 1) ^ (((s & 1) != 0) ? taps : 0);
      end
   endtask

   task automatic gen_rand(input int unsigned maxv);
      for (int unsigned i = 0; i < NSEQ; i++) seq[i] = $urandom_range(0, maxv);
   endtask

   task automatic run_measure(input string tag, input bit poke);
      int unsigned k_dec, e_per, e_max, e_stk, e_to;
      int unsigned got_k;
      model(k_dec, e_per, e_max, e_stk, e_to);
      @(negedge clock);
      start     = 1'b1;
      sample_in = W'(seq[0]);
      @(negedge clock);
      start     = 1'b0;
      chk({tag, ".armed.busy"},   32'(busy),    1);
      chk({tag, ".armed.done"},   32'(done),    0);
      chk({tag, ".armed.period"}, 32'(period),  0);
      chk({tag, ".armed.flags"},  32'({maximal, stuck, timeout}), 0);
      sample_in = W'(seq[1]);
      got_k = 0;
      for (int unsigned k = 1; k <= (1 << W) + 2 && got_k == 0; k++) begin
         @(negedge clock);
         if (done) begin
            got_k = k;
            start = 1'b0;
         end else begin
            sample_in = W'(seq[k+1]);
            start     = poke ? 1'($urandom_range(0, 1)) : 1'b0;
         end
      end
      start = 1'b0;
      chk({tag, ".edge"},    got_k,         k_dec);
      chk({tag, ".busy"},    32'(busy),     0);
      chk({tag, ".period"},  32'(period),   e_per);
      chk({tag, ".maximal"}, 32'(maximal),  e_max);
      chk({tag, ".stuck"},   32'(stuck),    e_stk);
      chk({tag, ".timeout"}, 32'(timeout),  e_to);
      @(negedge clock);
      chk({tag, ".hold.done"},   32'(done),   0);
      chk({tag, ".hold.period"}, 32'(period), e_per);
      chk({tag, ".hold.flags"},  32'({maximal, stuck, timeout}), (e_max << 2) | (e_stk << 1) | e_to);
   endtask

   initial begin
      // Reset asserted together with start: reset must win.
      reset = 1'b0;
      start = 1'b1;
      repeat (3) @(negedge clock);
      chk_idle("rst");
      reset = 1'b1;
      start = 1'b0;
      @(negedge clock);
      chk_idle("post_rst");

      gen_lfsr(4'b1100, 4'b1111, 3);
      run_measure("maximal", 1'b0);

      for (int unsigned i = 0; i < NSEQ; i++) seq[i] = 0;
      run_measure("lockup", 1'b0);

      seq[0] = 5;
      for (int unsigned i = 1; i < NSEQ; i++) seq[i] = ((i % 2) == 1) ? 9 : 3;
      run_measure("nonret", 1'b0);

      seq[0] = 7; seq[1] = 2;
      for (int unsigned i = 2; i < NSEQ; i++) seq[i] = 4;
      run_measure("fixedpt", 1'b0);

      // Reset on edge 6 of a measurement discards it with no done pulse.
      gen_lfsr(4'b1100, 4'b1111, 0);
      @(negedge clock);
      start     = 1'b1;
      sample_in = W'(seq[0]);
      for (int unsigned k = 0; k < 6; k++) begin
         @(negedge clock);
         start     = 1'b0;
         sample_in = W'(seq[k+1]);
      end
      reset = 1'b0;
      @(negedge clock);
      chk_idle("midrst");
      reset = 1'b1;
      repeat (3) begin
         @(negedge clock);
         chk({"midrst.quiet", ""}, 32'({busy, done}), 0);
      end
      run_measure("restart", 1'b0);

      run_measure("rearm_poke", 1'b1);
      run_measure("rearm_again", 1'b0);

      for (int unsigned n = 0; n < 24; n++) begin
         if ($urandom_range(0, 2) != 0)
            gen_lfsr($urandom_range(1, 15), $urandom_range(0, 15), $urandom_range(0, 15));
         else
            gen_rand($urandom_range(1, 15));
         run_measure($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
